// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the shared UART Tx and the
// arbiter. The arbiter uses the slave view; the client/Tx side uses master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                  req_last;
  logic [NUM_REQ-1:0]                  req_ready;
  logic                                tx_enable;
  logic [INPUT_DATA_WIDTH-1:0]         tx_data;
  logic                                tx_busy;
  logic [GW-1:0]                       grant_id;
  logic                                locked;
  logic                                err_timeout;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_enable, tx_data, grant_id, locked, err_timeout
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_enable, tx_data, grant_id, locked, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// streams. A multi-byte packet keeps the grant until its last byte. Each
// byte is sequenced as enable pulse -> busy rise -> busy fall, with an
// abort if the transmitter never reports busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int BUSY_TIMEOUT     = 64
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int W  = INPUT_DATA_WIDTH;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          r_state, w_next;
  logic [GW-1:0]   r_grant;
  logic [W-1:0]    r_data;
  logic            r_locked;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic [GW-1:0]   w_winner;
  logic [GW-1:0]   w_cand;
  logic            w_found;
  logic [W-1:0]    w_wdata;
  logic            w_wlast;
  logic            w_accept;
  logic            w_timeout;

  // Pick the winner: the frozen grantee while locked, otherwise the first
  // valid requester after the last grantee (wrapping NUM_REQ-1 -> 0).
  always_comb begin
    w_winner = r_grant;
    w_cand   = r_grant;
    w_found  = 1'b0;
    if (r_locked) begin
      w_found = bus.req_valid[r_grant];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_cand = GW'((int'(r_grant) + k) % NUM_REQ);
        if (!w_found && bus.req_valid[w_cand]) begin
          w_found  = 1'b1;
          w_winner = w_cand;
        end
      end
    end
  end

  // Select the winner's byte and last flag.
  always_comb begin
    w_wdata = '0;
    w_wlast = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == GW'(i)) begin
        w_wdata = bus.req_data[i*W +: W];
        w_wlast = bus.req_last[i];
      end
    end
  end

  // Accept only in ARB; ready is held low while reset is asserted.
  always_comb begin
    w_accept      = (r_state == ARB) && w_found && reset;
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_winner] = 1'b1;
  end

  // Next-state logic for the per-byte sequence.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      ARB:       if (w_found) w_next = ISSUE;
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_next = WAIT_DONE;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = ARB;
        end
      end
      WAIT_DONE: if (!bus.tx_busy) w_next = ARB;
      default:   w_next = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ARB;
    else        r_state <= w_next;
  end

  // Datapath: latch byte/grant on accept, run the busy-wait counter, flag timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant  <= GW'(NUM_REQ - 1);
      r_data   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_err <= w_timeout;
      if (w_accept) begin
        r_data   <= w_wdata;
        r_grant  <= w_winner;
        r_locked <= ~w_wlast;
      end
      if (w_timeout) r_locked <= 1'b0;
      if (r_state == ISSUE)
        r_cnt <= '0;
      else if (r_state == WAIT_BUSY && !bus.tx_busy && !w_timeout)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.tx_enable   = (r_state == ISSUE);
  assign bus.tx_data     = r_data;
  assign bus.grant_id    = r_grant;
  assign bus.locked      = r_locked;
  assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the arbiter,
// a small Tx model answers enable with busy, and a scoreboard pairs each
// accepted byte with the next tx_enable.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int BT = 64;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .INPUT_DATA_WIDTH(W)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .INPUT_DATA_WIDTH(W), .BUSY_TIMEOUT(BT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc, en_cyc, err_cyc;
  int n_acc = 0, n_en = 0, n_err = 0;
  int mode  = 0;   // 0: busy 2 cycles after enable for 20; 1: never busy; 2: busy with enable
  int tcnt  = 0;
  logic busy_reg;

  logic [8:0]    rq [NR][$];   // {last, data} per requester
  exp_t          sb[$];
  int            order_q[$];
  logic          lock_q[$];
  logic [NR-1:0] acc_mask = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Tx model
  always @(posedge clk) begin
    if (bus.tx_enable) tcnt <= 1;
    else if (tcnt != 0) tcnt <= (tcnt >= ((mode == 0) ? 21 : 3)) ? 0 : tcnt + 1;
  end
  assign busy_reg    = (mode == 0) ? (tcnt >= 2) : (mode == 2) ? (tcnt >= 1) : 1'b0;
  assign bus.tx_busy = busy_reg || (mode == 2 && bus.tx_enable);

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_last[i]        = rq[i][0][8];
        bus.req_data[i*W +: W] = rq[i][0][7:0];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_last[i]        = 1'b0;
        bus.req_data[i*W +: W] = '0;
      end
    end
  endtask

  // Requester side: retire accepted bytes just after the accepting edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++)
      if (acc_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    acc_mask = '0;
    drive();
  end

  // Monitor/scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [NR-1:0] acc;
    exp_t e;
    if (rst_n) begin
      acc = bus.req_ready & bus.req_valid;
      if (acc != '0) begin
        chk("ready_onehot", $countones(bus.req_ready), 1);
        for (int i = 0; i < NR; i++)
          if (acc[i]) begin
            sb.push_back({2'(i), bus.req_data[i*W +: W]});
            order_q.push_back(i);
          end
        acc_mask = acc;
        acc_cyc  = cyc;
        n_acc++;
      end
      if (bus.tx_enable) begin
        n_en++;
        en_cyc = cyc;
        lock_q.push_back(bus.locked);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("tx_data", bus.tx_data, e.data);
          chk("tx_grant", bus.grant_id, e.id);
        end
      end
      if (bus.err_timeout) begin
        n_err++;
        err_cyc = cyc;
        chk("err_latency", cyc - en_cyc, 65);
        chk("err_locked_clr", bus.locked, 0);
      end
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 0;
    return sb.size() == 0;
  endfunction

  task automatic wait_idle(input string tag);
    int b = 0;
    while (b < 3000 && !(all_empty() && tcnt == 0 && !bus.tx_busy && !bus.tx_enable)) begin
      @(negedge clk);
      b++;
    end
    chk({tag, "_idle"}, b < 3000, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_order(input string tag, input int exp[$]);
    chk({tag, "_cnt"}, order_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < order_q.size(); i++)
      chk(tag, order_q[i], exp[i]);
  endtask

  initial begin : seq
    int b, e0, a0, r0;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_enable", bus.tx_enable, 0);
    chk("rst_data", bus.tx_data, 0);
    chk("rst_grant", bus.grant_id, NR - 1);
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: every requester valid, all single-byte packets
    rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h14});
    rq[1].push_back({1'b1, 8'h11}); rq[1].push_back({1'b1, 8'h15});
    rq[2].push_back({1'b1, 8'h12});
    rq[3].push_back({1'b1, 8'h13});
    wait_idle("fair");
    chk_order("fair_order", '{0, 1, 2, 3, 0, 1});

    // Single byte from requester 2
    order_q.delete();
    rq[2].push_back({1'b1, 8'hA5});
    wait_idle("single");
    chk_order("single_order", '{2});
    chk("single_latency", en_cyc - acc_cyc, 1);
    chk("single_hold", bus.tx_data, 8'hA5);
    chk("single_grant", bus.grant_id, 2);
    chk("single_locked", bus.locked, 0);

    // Packet lock: prime grant to 0, then req1 sends 3 bytes vs req0/req3
    rq[0].push_back({1'b1, 8'h20});
    wait_idle("prime");
    order_q.delete(); lock_q.delete();
    rq[1].push_back({1'b0, 8'hA1}); rq[1].push_back({1'b0, 8'hB1}); rq[1].push_back({1'b1, 8'hC1});
    rq[0].push_back({1'b1, 8'h30});
    rq[3].push_back({1'b1, 8'h33});
    wait_idle("lock");
    chk_order("lock_order", '{1, 1, 1, 3, 0});
    for (int i = 0; i < 5 && i < lock_q.size(); i++)
      chk("lock_flag", lock_q[i], (i < 2) ? 1 : 0);

    // Timeout: transmitter never goes busy
    mode = 1;
    order_q.delete(); lock_q.delete();
    r0 = n_err;
    rq[3].push_back({1'b0, 8'h55}); rq[3].push_back({1'b1, 8'h56});
    rq[0].push_back({1'b1, 8'h66});
    b = 0;
    while (b < 1000 && n_err - r0 < 3) begin @(negedge clk); b++; end
    chk("tmo_done", b < 1000, 1);
    repeat (3) @(negedge clk);
    chk("tmo_count", n_err - r0, 3);
    chk_order("tmo_order", '{3, 0, 3});
    chk("tmo_first_locked", lock_q.size() > 0 && lock_q[0], 1);
    chk("tmo_err_low", bus.err_timeout, 0);
    mode = 0;
    wait_idle("tmo");

    // Reset during WAIT_DONE of a locked packet
    order_q.delete();
    r0 = n_err;
    rq[1].push_back({1'b0, 8'h11}); rq[1].push_back({1'b1, 8'h22});
    b = 0;
    while (b < 200 && !bus.tx_busy) begin @(negedge clk); b++; end
    chk("mid_busy_seen", b < 200, 1);
    repeat (3) @(negedge clk);
    chk("mid_locked_before", bus.locked, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_enable", bus.tx_enable, 0);
    chk("mid_data", bus.tx_data, 0);
    chk("mid_grant", bus.grant_id, NR - 1);
    chk("mid_locked", bus.locked, 0);
    chk("mid_err", bus.err_timeout, 0);
    chk("mid_ready", bus.req_ready, 0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    b = 0;
    while (b < 200 && tcnt != 0) begin @(negedge clk); b++; end
    chk("mid_tx_quiet", b < 200, 1);
    @(negedge clk);
    rst_n = 1'b1;
    order_q.delete();
    rq[2].push_back({1'b1, 8'h33});
    rq[0].push_back({1'b1, 8'h44});
    wait_idle("post_rst");
    chk_order("post_rst_order", '{0, 2});
    chk("post_rst_no_err", n_err - r0, 0);

    // Busy-early transmitter, 100 random bytes
    mode = 2;
    e0 = n_en; a0 = n_acc; r0 = n_err;
    for (int n = 0; n < 100; n++)
      rq[$urandom_range(0, NR - 1)].push_back({1'($urandom_range(0, 1)), 8'($urandom)});
    for (int i = 0; i < NR; i++)
      if (rq[i].size() > 0) rq[i][rq[i].size() - 1][8] = 1'b1;
    wait_idle("rand");
    chk("rand_accepts", n_acc - a0, 100);
    chk("rand_enables", n_en - e0, 100);
    chk("rand_no_err", n_err - r0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
